digit_serial_adder: RTL

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, holding the inter-digit carry in a flip-flop. It is the sequential, area-reduced successor to the single-bit full-adder cell. It serves datapaths that trade latency for adder width. A start/busy/done handshake lets a controller issue one operation at a time. Results are registered and held stable until the next operation completes.

---
 rtl/digit_serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per cycle, LSB digit first.
// Latency: NDIG = WIDTH/DIGIT RUN cycles after the accepting edge; done pulses the cycle after.
// Backpressure: start is ignored while busy; it is accepted in IDLE and in the DONE cycle.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic             last;
    logic             accept;

    // Select the active digit of each operand and merge the new sum digit into the accumulator.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                dig_a = opa_q[i*DIGIT +: DIGIT];
                dig_b = opb_q[i*DIGIT +: DIGIT];
            end
        end
    end

    always_comb begin
        dsum = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the digit's top bit is recovered from its sum bit and its two operand bits.
        msb_cin = dsum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
        acc_d   = acc_q;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                acc_d[i*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
            end
        end
    end

    assign last   = (cnt_q == CW'(NDIG - 1));
    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= acc_d;
            carry_q <= dsum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            // Outputs move only here, as a whole, on the final digit.
            if (last) begin
                s_q    <= acc_d;
                cout_q <= dsum[DIGIT];
                ovf_q  <= msb_cin ^ dsum[DIGIT];
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
